// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz VGA raster generator: pixel counters, valid, delayed syncs and a per-frame tick.
// Optional frame counter enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_DELAY = 2
) (
  input  logic       clk_25m,
  input  logic       rst,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       valid,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_param_check
    $error("vga_timing_gen: totals must fit 10-bit counters and SYNC_DELAY must be 0..4");
  end

  logic [9:0] hc_next;
  logic [9:0] vc_next;
  logic       valid_next;
  logic       hs_raw_next;
  logic       vs_raw_next;
  logic       tick_next;
  logic       hs_raw;
  logic       vs_raw;

  // Everything registered is derived from the next-state counters so it stays coherent with hc/vc.
  always_comb begin
    // NOTE: default every comb output first so no path leaves a value held, which would infer a latch.
    hc_next = hc + 10'd1;
    vc_next = vc;
    if (hc == H_LAST) begin
      hc_next = 10'd0;
      vc_next = (vc == V_LAST) ? 10'd0 : vc + 10'd1;
    end
    valid_next  = (hc_next < H_VIS) && (vc_next < V_VIS);
    hs_raw_next = !((hc_next >= HS_FIRST) && (hc_next <= HS_LAST));
    vs_raw_next = !((vc_next >= VS_FIRST) && (vc_next <= VS_LAST));
    tick_next   = (hc_next == 10'd0) && (vc_next == V_VIS);
  end

  always_ff @(posedge clk_25m) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
    if (rst) begin
      hc         <= 10'd0;
      vc         <= 10'd0;
      valid      <= 1'b0;
      frame_tick <= 1'b0;
      hs_raw     <= 1'b1;
      vs_raw     <= 1'b1;
    end else begin
      hc         <= hc_next;
      vc         <= vc_next;
      valid      <= valid_next;
      frame_tick <= tick_next;
      hs_raw     <= hs_raw_next;
      vs_raw     <= vs_raw_next;
    end
  end

  // Extra sync delay matches the downstream ROM/colour register pipeline.
  if (SYNC_DELAY == 0) begin : g_no_delay
    assign hsync = hs_raw;
    assign vsync = vs_raw;
  end else begin : g_delay
    logic [SYNC_DELAY-1:0] hs_pipe;
    logic [SYNC_DELAY-1:0] vs_pipe;

    always_ff @(posedge clk_25m) begin
      if (rst) begin
        hs_pipe <= '1;
        vs_pipe <= '1;
      end else begin
        hs_pipe[0] <= hs_raw;
        vs_pipe[0] <= vs_raw;
        for (int i = 1; i < SYNC_DELAY; i++) begin
          hs_pipe[i] <= hs_pipe[i-1];
          vs_pipe[i] <= vs_pipe[i-1];
        end
      end
    end

    assign hsync = hs_pipe[SYNC_DELAY-1];
    assign vsync = vs_pipe[SYNC_DELAY-1];
  end

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk_25m) begin
    if (rst) begin
      frame_cnt_q <= 8'd0;
    end else if (tick_next) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: two full-size instances (SYNC_DELAY 2 and 0) for line timing
// and one reduced-geometry instance (12x8 raster, 96-cycle frame) for frame-level behaviour.
module tb_vga_timing_gen;

  logic clk_25m = 1'b0;
  logic rst     = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  always #20 clk_25m = ~clk_25m;

`ifdef VGA_FRAME_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic [9:0] d2_hc, d2_vc, d0_hc, d0_vc, sm_hc, sm_vc;
  logic       d2_valid, d2_hsync, d2_vsync, d2_tick;
  logic       d0_valid, d0_hsync, d0_vsync, d0_tick;
  logic       sm_valid, sm_hsync, sm_vsync, sm_tick;
  logic [7:0] d2_cnt, d0_cnt, sm_cnt;

  vga_timing_gen #(.SYNC_DELAY(2)) dut_d2 (
    .clk_25m(clk_25m), .rst(rst), .hc(d2_hc), .vc(d2_vc), .valid(d2_valid),
    .hsync(d2_hsync), .vsync(d2_vsync), .frame_tick(d2_tick), .frame_cnt(d2_cnt)
  );

  vga_timing_gen #(.SYNC_DELAY(0)) dut_d0 (
    .clk_25m(clk_25m), .rst(rst), .hc(d0_hc), .vc(d0_vc), .valid(d0_valid),
    .hsync(d0_hsync), .vsync(d0_vsync), .frame_tick(d0_tick), .frame_cnt(d0_cnt)
  );

  // Small raster: hsync low hc 9..10 of 12, vsync low vc 5..6 of 8, frame_tick at (0,4).
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_DELAY(2)
  ) dut_sm (
    .clk_25m(clk_25m), .rst(rst), .hc(sm_hc), .vc(sm_vc), .valid(sm_valid),
    .hsync(sm_hsync), .vsync(sm_vsync), .frame_tick(sm_tick), .frame_cnt(sm_cnt)
  );

  localparam logic [24:0] RST_VEC = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_25m);
      checks++;
      if ({d2_hc, d2_vc, d2_valid, d2_hsync, d2_vsync, d2_tick, d2_cnt} !== {RST_VEC, 8'd0}) begin
        errors++;
        $display("FAIL reset_d2 cyc %0d: hc=%0d vc=%0d valid=%b hs=%b vs=%b tick=%b cnt=%0d, want 0 0 0 1 1 0 0",
                 i, d2_hc, d2_vc, d2_valid, d2_hsync, d2_vsync, d2_tick, d2_cnt);
      end
      checks++;
      if ({d0_hc, d0_vc, d0_valid, d0_hsync, d0_vsync, d0_tick, d0_cnt} !== {RST_VEC, 8'd0}) begin
        errors++;
        $display("FAIL reset_d0 cyc %0d: hc=%0d vc=%0d valid=%b hs=%b vs=%b tick=%b cnt=%0d, want 0 0 0 1 1 0 0",
                 i, d0_hc, d0_vc, d0_valid, d0_hsync, d0_vsync, d0_tick, d0_cnt);
      end
      checks++;
      if ({sm_hc, sm_vc, sm_valid, sm_hsync, sm_vsync, sm_tick, sm_cnt} !== {RST_VEC, 8'd0}) begin
        errors++;
        $display("FAIL reset_sm cyc %0d: hc=%0d vc=%0d valid=%b hs=%b vs=%b tick=%b cnt=%0d, want 0 0 0 1 1 0 0",
                 i, sm_hc, sm_vc, sm_valid, sm_hsync, sm_vsync, sm_tick, sm_cnt);
      end
    end
    rst = 1'b0;
    @(negedge clk_25m);
    checks++;
    if ({d2_hc, d2_vc, d2_valid, d2_hsync, d2_vsync} !== {10'd1, 10'd0, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL first_cycle_d2: hc=%0d vc=%0d valid=%b hs=%b vs=%b, want 1 0 1 1 1",
               d2_hc, d2_vc, d2_valid, d2_hsync, d2_vsync);
    end
    checks++;
    if ({d0_hc, d0_vc, d0_valid, d0_hsync} !== {10'd1, 10'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL first_cycle_d0: hc=%0d vc=%0d valid=%b hs=%b, want 1 0 1 1",
               d0_hc, d0_vc, d0_valid, d0_hsync);
    end
    checks++;
    if ({sm_hc, sm_vc, sm_valid, sm_hsync} !== {10'd1, 10'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL first_cycle_sm: hc=%0d vc=%0d valid=%b hs=%b, want 1 0 1 1",
               sm_hc, sm_vc, sm_valid, sm_hsync);
    end
  endtask

  task automatic test_hsync();
    logic p2, p0, e2, e0, ev;
    int   run2 = 0, run0 = 0, falls2 = 0, falls0 = 0;
    bit   in2 = 0, in0 = 0;
    int   h2, h0;
    p2 = d2_hsync;
    p0 = d0_hsync;
    for (int c = 0; c < 1700; c++) begin
      @(negedge clk_25m);
      h2 = int'(d2_hc);
      h0 = int'(d0_hc);
      e2 = !(h2 >= 658 && h2 <= 753);
      e0 = !(h0 >= 656 && h0 <= 751);
      ev = (h2 < 640) && (int'(d2_vc) < 480);
      checks++;
      if (d2_hsync !== e2) begin
        errors++;
        $display("FAIL hsync_d2 hc=%0d: got %b want %b", h2, d2_hsync, e2);
      end
      checks++;
      if (d0_hsync !== e0) begin
        errors++;
        $display("FAIL hsync_d0 hc=%0d: got %b want %b", h0, d0_hsync, e0);
      end
      checks++;
      if (d2_valid !== ev) begin
        errors++;
        $display("FAIL valid_d2 hc=%0d vc=%0d: got %b want %b", h2, d2_vc, d2_valid, ev);
      end
      if (p2 && !d2_hsync) begin
        falls2++; in2 = 1; run2 = 0;
        checks++;
        if (h2 != 658) begin
          errors++;
          $display("FAIL hsync_fall_d2: at hc=%0d want 658", h2);
        end
      end
      if (in2 && !d2_hsync) run2++;
      if (!p2 && d2_hsync && in2) begin
        in2 = 0;
        checks++;
        if (run2 != 96) begin
          errors++;
          $display("FAIL hsync_width_d2: got %0d want 96", run2);
        end
      end
      if (p0 && !d0_hsync) begin
        falls0++; in0 = 1; run0 = 0;
        checks++;
        if (h0 != 656) begin
          errors++;
          $display("FAIL hsync_fall_d0: at hc=%0d want 656", h0);
        end
      end
      if (in0 && !d0_hsync) run0++;
      if (!p0 && d0_hsync && in0) begin
        in0 = 0;
        checks++;
        if (run0 != 96) begin
          errors++;
          $display("FAIL hsync_width_d0: got %0d want 96", run0);
        end
      end
      p2 = d2_hsync;
      p0 = d0_hsync;
    end
    checks++;
    if (falls2 != 2 || falls0 != 2) begin
      errors++;
      $display("FAIL hsync_pulse_count: d2=%0d d0=%0d want 2 2", falls2, falls0);
    end
  endtask

  task automatic test_vsync();
    logic pv, ev, eh;
    int   p, pd, run = 0, falls = 0;
    bit   inrun = 0;
    pv = sm_vsync;
    for (int c = 0; c < 192; c++) begin
      @(negedge clk_25m);
      p  = int'(sm_vc) * 12 + int'(sm_hc);
      pd = (p + 94) % 96;
      ev = !((pd / 12) >= 5 && (pd / 12) <= 6);
      eh = !((pd % 12) >= 9 && (pd % 12) <= 10);
      checks++;
      if (sm_vsync !== ev) begin
        errors++;
        $display("FAIL vsync_sm hc=%0d vc=%0d: got %b want %b", sm_hc, sm_vc, sm_vsync, ev);
      end
      checks++;
      if (sm_hsync !== eh) begin
        errors++;
        $display("FAIL hsync_sm hc=%0d vc=%0d: got %b want %b", sm_hc, sm_vc, sm_hsync, eh);
      end
      if (pv && !sm_vsync) begin
        falls++; inrun = 1; run = 0;
        checks++;
        if (sm_hc !== 10'd2 || sm_vc !== 10'd5) begin
          errors++;
          $display("FAIL vsync_fall_sm: at hc=%0d vc=%0d want hc=2 vc=5", sm_hc, sm_vc);
        end
      end
      if (inrun && !sm_vsync) run++;
      if (!pv && sm_vsync && inrun) begin
        inrun = 0;
        checks++;
        if (run != 24) begin
          errors++;
          $display("FAIL vsync_width_sm: got %0d want 24", run);
        end
      end
      pv = sm_vsync;
    end
    checks++;
    if (falls != 2) begin
      errors++;
      $display("FAIL vsync_pulse_count: got %0d want 2", falls);
    end
  endtask

  task automatic test_full_frame();
    int  ph, pv, h, v, ticks = 0, last = 0, vcount = 0, vwraps = 0;
    logic ev;
    ph = int'(sm_hc);
    pv = int'(sm_vc);
    for (int c = 0; c < 288; c++) begin
      @(negedge clk_25m);
      h = int'(sm_hc);
      v = int'(sm_vc);
      checks++;
      if (ph == 11) begin
        if (pv == 7) vwraps++;
        if (h != 0 || v != ((pv == 7) ? 0 : pv + 1)) begin
          errors++;
          $display("FAIL wrap_sm: from hc=%0d vc=%0d got hc=%0d vc=%0d", ph, pv, h, v);
        end
      end else if (h != ph + 1 || v != pv) begin
        errors++;
        $display("FAIL step_sm: from hc=%0d vc=%0d got hc=%0d vc=%0d", ph, pv, h, v);
      end
      ev = (h < 8) && (v < 4);
      checks++;
      if (sm_valid !== ev) begin
        errors++;
        $display("FAIL valid_sm hc=%0d vc=%0d: got %b want %b", h, v, sm_valid, ev);
      end
      if (sm_tick) begin
        ticks++;
        checks++;
        if (h != 0 || v != 4) begin
          errors++;
          $display("FAIL tick_pos_sm: at hc=%0d vc=%0d want hc=0 vc=4", h, v);
        end
        if (ticks > 1) begin
          checks++;
          if (c - last != 96 || vcount != 32) begin
            errors++;
            $display("FAIL tick_period_sm: period=%0d valid=%0d want 96 32", c - last, vcount);
          end
        end
        last = c;
        vcount = 0;
      end
      if (sm_valid) vcount++;
      ph = h;
      pv = v;
    end
    checks++;
    if (ticks != 3 || vwraps != 3) begin
      errors++;
      $display("FAIL frame_events_sm: ticks=%0d vwraps=%0d want 3 3", ticks, vwraps);
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    while (!(sm_hc == 10'd5 && sm_vc == 10'd2) && n < 200) begin
      @(negedge clk_25m);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL mid_reset_wait: hc=5 vc=2 not reached in 200 cycles");
    end
    rst = 1'b1;
    @(negedge clk_25m);
    checks++;
    if ({sm_hc, sm_vc, sm_valid, sm_hsync, sm_vsync, sm_tick, sm_cnt} !== {RST_VEC, 8'd0}) begin
      errors++;
      $display("FAIL mid_reset_sm: hc=%0d vc=%0d valid=%b hs=%b vs=%b tick=%b cnt=%0d, want 0 0 0 1 1 0 0",
               sm_hc, sm_vc, sm_valid, sm_hsync, sm_vsync, sm_tick, sm_cnt);
    end
    checks++;
    if ({d2_hc, d2_vc, d2_valid, d2_hsync} !== {10'd0, 10'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset_d2: hc=%0d vc=%0d valid=%b hs=%b, want 0 0 0 1", d2_hc, d2_vc, d2_valid, d2_hsync);
    end
    rst = 1'b0;
    @(negedge clk_25m);
    checks++;
    if ({sm_hc, sm_vc, sm_valid} !== {10'd1, 10'd0, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset_restart: hc=%0d vc=%0d valid=%b, want 1 0 1", sm_hc, sm_vc, sm_valid);
    end
    n = 0;
    while (!sm_tick && n < 200) begin
      @(negedge clk_25m);
      n++;
    end
    checks++;
    if (!sm_tick || n != 47) begin
      errors++;
      $display("FAIL mid_reset_tick: tick=%b after %0d cycles, want 1 after 47", sm_tick, n);
    end
    checks++;
    if (sm_cnt !== (CNT_EN ? 8'd1 : 8'd0)) begin
      errors++;
      $display("FAIL mid_reset_cnt: got %0d want %0d", sm_cnt, CNT_EN ? 1 : 0);
    end
  endtask

  task automatic test_frame_cnt();
    int ticks = 1;
    logic [7:0] prev_cnt, exp_cnt;
    prev_cnt = sm_cnt;
    for (int c = 0; c < 255 * 96 + 50 && ticks < 256; c++) begin
      @(negedge clk_25m);
      if (sm_tick) begin
        ticks++;
        exp_cnt = CNT_EN ? 8'(ticks) : 8'd0;
        checks++;
        if (sm_cnt !== exp_cnt) begin
          errors++;
          $display("FAIL frame_cnt tick %0d: got %0d want %0d", ticks, sm_cnt, exp_cnt);
        end
        if (ticks == 256 && CNT_EN) begin
          checks++;
          if (prev_cnt !== 8'd255 || sm_cnt !== 8'd0) begin
            errors++;
            $display("FAIL frame_cnt_wrap: went %0d -> %0d want 255 -> 0", prev_cnt, sm_cnt);
          end
        end
        prev_cnt = sm_cnt;
      end
    end
    checks++;
    if (ticks != 256) begin
      errors++;
      $display("FAIL frame_cnt_ticks: saw %0d ticks want 256", ticks);
    end
  endtask

  initial begin
    test_reset();
    test_hsync();
    test_vsync();
    test_full_frame();
    test_mid_reset();
    test_frame_cnt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Free-running 640x480@60 Hz VGA raster generator clocked by the 25 MHz pixel clock. It produces the pixel coordinates `hc`/`vc` and the `valid` flag consumed by the pixel/colour stage (`vga_RGB`). It also drives the monitor `hsync`/`vsync` pins, delayed to line up with that stage's registered RGB output. A once-per-frame `frame_tick` paces the game-logic blocks (player, enemy, bullet movers).

## Interface
Parameters:
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch (cycles)
- `H_SYNC`, 96, hsync pulse width (cycles)
- `H_BACK`, 48, horizontal back porch (cycles)
- `V_VISIBLE`, 480, active lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `SYNC_DELAY`, 2, extra clk_25m cycles applied to hsync/vsync; legal range 0..4

Ports:
- `clk_25m`  in  1  pixel clock
- `rst`  in  1  reset, synchronous, active-high
- `hc`  out  10  horizontal counter, 0..H_TOTAL-1 (H_TOTAL = 800)
- `vc`  out  10  vertical counter, 0..V_TOTAL-1 (V_TOTAL = 525)
- `valid`  out  1  1 when hc < H_VISIBLE and vc < V_VISIBLE
- `hsync`  out  1  horizontal sync, active-low, delayed
- `vsync`  out  1  vertical sync, active-low, delayed
- `frame_tick`  out  1  one-cycle pulse at start of vertical blanking
- `frame_cnt`  out  8  frame counter, wraps (see Configuration)

## Operation
- All outputs are registered. There is no combinational path from inputs to outputs.
- hc increments by 1 every cycle. At hc = H_TOTAL-1, hc wraps to 0 and vc increments.
- At vc = V_TOTAL-1 with hc = H_TOTAL-1, both counters wrap to 0.
- `valid` is computed from the next-state counter values, so it is coherent with the hc/vc it is issued with.
- Raw hsync is low for hc in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656, 751].
- Raw vsync is low for vc in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] = [490, 491], across whole lines.
- Raw syncs pass through a SYNC_DELAY-deep shift register. Its stages reset to 1. With SYNC_DELAY = 0 the syncs are registered alongside hc/vc.
- `frame_tick` is 1 exactly in the cycle where hc = 0 and vc = V_VISIBLE (480). It is 0 otherwise.
- `frame_cnt` increments by 1 in the same cycle that frame_tick is issued. It wraps 255 -> 0.
- Counter arithmetic is 10-bit unsigned. H_TOTAL and V_TOTAL must each be ≤ 1024; this is a compile-time check, not runtime behaviour.

## Timing
- Reset values while rst = 1: hc = 0, vc = 0, valid = 0, hsync = 1, vsync = 1, frame_tick = 0, frame_cnt = 0. All sync delay stages = 1.
- First edge with rst = 0: hc = 1, vc = 0, valid = 1. The pixel (0,0) of the first frame after reset is skipped by design.
- Reset asserted mid-frame: on the next edge every output takes its reset value. Timing restarts from the state above; no partial frame_tick is emitted.
- Sync latency relative to the counters is SYNC_DELAY cycles. The default of 2 matches the two-register ROM/colour pipeline downstream.
- Period between frame_tick pulses: 800 x 525 = 420000 cycles.
- Valid pixels per frame: 307200. Valid cycles per line: 640, contiguous.

## Configuration
- Macro `VGA_FRAME_CNT_EN`.
- Defined: frame_cnt is an 8-bit register behaving as described above.
- Undefined: no counter is synthesised and frame_cnt is tied to 8'd0. All other outputs are unaffected.

## Test plan
- Reset check: hold rst for 5 cycles, then release. Required: all outputs at reset values during rst; the first post-reset cycle shows hc = 1, vc = 0, valid = 1, hsync = 1.
- Hsync check with SYNC_DELAY = 2: hsync falls 2 cycles after the cycle where hc = 656, and stays low for exactly 96 cycles. Repeat with SYNC_DELAY = 0: it falls in the hc = 656 cycle.
- Vsync check: vsync is low for exactly 1600 consecutive cycles, starting SYNC_DELAY cycles after the cycle where hc = 0 and vc = 490.
- Full-frame check: run 2 frames. Required: frame_tick pulses exactly 420000 cycles apart, each coincident with hc = 0 and vc = 480. Valid asserts exactly 307200 times per frame. Each wrap goes hc 799 -> 0 and vc 524 -> 0.
- Mid-frame reset: assert rst for 1 cycle at hc = 300, vc = 200. Required: next cycle shows hc = 0, vc = 0, valid = 0, frame_cnt = 0. The first frame_tick then arrives 480 x 800 - 1 = 383999 cycles after rst deasserts.
- Frame counter: with `VGA_FRAME_CNT_EN` defined, run 256 frames and check frame_cnt goes 255 -> 0 on the 256th tick. With the macro undefined, frame_cnt stays 0 throughout.
